// File: rtl/apb_reg_bank.sv
// apb_reg_bank
//   APB slave register bank sitting behind the UART-to-APB bridge.
//   Word map (byte offsets, paddr[1:0] ignored):
//     0x00 ID (RO) | 0x04 CTRL (RW) | 0x08 WR_CNT (RO, completed writes)
//     0x0C + 4*i SCRATCHi (RW), i = 0 .. REG_NUM-1; anything else is unmapped.
//   Every transfer is stretched by WAIT_CYCLES access-phase wait states so the
//   bridge's pready polling loop is exercised.
//
//   Optional build macro APB_PSLVERR_EN: adds apb_pslverr, raised on the
//   pready cycle for writes to RO/unmapped words and reads of unmapped words;
//   such writes are not counted in WR_CNT.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   apb_psel          slave select
//   apb_paddr         byte address
//   apb_pwrite        1 = write, 0 = read
//   apb_penable       access phase
//   apb_pwdata        write data
//   apb_pready        transfer complete (combinational from FSM state)
//   apb_prdata        read data, zero except on the pready cycle
//   apb_pslverr       slave error (only with APB_PSLVERR_EN)
//   ctrl_out          current CTRL register value
module apb_reg_bank #(
  parameter int unsigned               APB_ADDR_WIDTH = 16,
  parameter int unsigned               APB_DATA_WIDTH = 32,
  parameter int unsigned               REG_NUM        = 8,
  parameter int unsigned               WAIT_CYCLES    = 2,
  parameter logic [APB_DATA_WIDTH-1:0] ID_VALUE       = 32'hA5A5_0100
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      apb_psel,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  input  logic                      apb_pwrite,
  input  logic                      apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  output logic                      apb_pready,
  output logic [APB_DATA_WIDTH-1:0] apb_prdata,
`ifdef APB_PSLVERR_EN
  output logic                      apb_pslverr,
`endif
  output logic [APB_DATA_WIDTH-1:0] ctrl_out
);

  localparam int unsigned IDX_W = APB_ADDR_WIDTH - 2;
  localparam logic [3:0]                WAIT_INIT      = 4'(WAIT_CYCLES);
  localparam logic [IDX_W-1:0]          IDX_ID         = IDX_W'(32'd0);
  localparam logic [IDX_W-1:0]          IDX_CTRL       = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0]          IDX_CNT        = IDX_W'(32'd2);
  localparam logic [APB_DATA_WIDTH-1:0] UNMAPPED_VALUE = APB_DATA_WIDTH'(32'hDEAD_BEEF);
  localparam logic [APB_DATA_WIDTH-1:0] CNT_STEP       = APB_DATA_WIDTH'(32'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [IDX_W-1:0]          idx_r;
  logic                      write_r;
  logic [APB_DATA_WIDTH-1:0] wdata_r;
  logic [3:0]                wait_cnt_r;
  logic [APB_DATA_WIDTH-1:0] ctrl_r;
  logic [APB_DATA_WIDTH-1:0] wr_cnt_r;
  logic [APB_DATA_WIDTH-1:0] scratch_r [REG_NUM];

  logic                      setup_s;
  logic                      bus_access_s;
  logic                      pready_s;
  logic                      err_s;
  logic                      commit_s;
  logic                      hit_id_s;
  logic                      hit_ctrl_s;
  logic                      hit_cnt_s;
  logic                      hit_scr_s;
  logic [REG_NUM-1:0]        scr_sel_s;
  logic [APB_DATA_WIDTH-1:0] rd_mux_s;
  logic                      unused_addr_s;

  // Byte-lane bits carry no meaning for a word-only register bank.
  assign unused_addr_s = ^apb_paddr[1:0];
  assign setup_s       = apb_psel & ~apb_penable;
  assign bus_access_s  = apb_psel & apb_penable;

  // State register, transfer latch and wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      write_r    <= 1'b0;
      wdata_r    <= '0;
      wait_cnt_r <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_IDLE) && setup_s) begin
        idx_r      <= apb_paddr[APB_ADDR_WIDTH-1:2];
        write_r    <= apb_pwrite;
        wdata_r    <= apb_pwdata;
        wait_cnt_r <= WAIT_INIT;
      end else if ((state_r == ST_ACCESS) && (wait_cnt_r != 4'd0)) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end
    end
  end

  // Next state and pready; a dropped psel/penable before pready abandons the transfer.
  always_comb begin
    state_nxt_s = state_r;
    pready_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (setup_s) state_nxt_s = ST_SETUP;
        else         state_nxt_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (bus_access_s) state_nxt_s = ST_ACCESS;
        else              state_nxt_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (!bus_access_s) begin
          state_nxt_s = ST_IDLE;
        end else if (wait_cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
          pready_s    = 1'b1;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Address decode and read multiplexer on the latched word index.
  always_comb begin
    hit_id_s   = (idx_r == IDX_ID);
    hit_ctrl_s = (idx_r == IDX_CTRL);
    hit_cnt_s  = (idx_r == IDX_CNT);
    scr_sel_s  = '0;
    for (int i = 0; i < int'(REG_NUM); i++) begin
      scr_sel_s[i] = (idx_r == IDX_W'(32'd3 + 32'(i)));
    end
    hit_scr_s = |scr_sel_s;
    rd_mux_s  = '0;
    if (hit_id_s) begin
      rd_mux_s = ID_VALUE;
    end else if (hit_ctrl_s) begin
      rd_mux_s = ctrl_r;
    end else if (hit_cnt_s) begin
      rd_mux_s = wr_cnt_r;
    end else if (hit_scr_s) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        rd_mux_s = rd_mux_s | (scratch_r[i] & {APB_DATA_WIDTH{scr_sel_s[i]}});
      end
    end else begin
      rd_mux_s = UNMAPPED_VALUE;
    end
  end

`ifdef APB_PSLVERR_EN
  // Writes may only land in CTRL or scratch; reads fail only when unmapped.
  assign err_s = pready_s & (write_r ? ~(hit_ctrl_s | hit_scr_s)
                                     : ~(hit_id_s | hit_ctrl_s | hit_cnt_s | hit_scr_s));
  assign apb_pslverr = err_s;
`else
  assign err_s = 1'b0;
`endif

  // A write takes effect exactly once, on its pready cycle.
  assign commit_s = pready_s & write_r & ~err_s;

  // Architectural registers: CTRL, completed-write counter, scratch bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= '0;
      wr_cnt_r <= '0;
      for (int i = 0; i < int'(REG_NUM); i++) begin
        scratch_r[i] <= '0;
      end
    end else begin
      if (commit_s) begin
        wr_cnt_r <= wr_cnt_r + CNT_STEP;
      end
      if (commit_s && hit_ctrl_s) begin
        ctrl_r <= wdata_r;
      end
      for (int i = 0; i < int'(REG_NUM); i++) begin
        if (commit_s && scr_sel_s[i]) begin
          scratch_r[i] <= wdata_r;
        end
      end
    end
  end

  assign apb_pready = pready_s;
  assign apb_prdata = pready_s ? rd_mux_s : '0;
  assign ctrl_out   = ctrl_r;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: two instances (WAIT_CYCLES=2 and WAIT_CYCLES=0)
// driven by directed and random APB transfers, compared against a
// register-map model held in plain arrays.
module tb_apb_reg_bank;

  localparam int NREG = 8;
  localparam int WC0  = 2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  psel;
  logic [15:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [1:0]  pready;
  logic [1:0]  pslverr;
  logic [31:0] prdata0, prdata1;
  logic [31:0] ctrl0, ctrl1;

  int total;
  int passed;
  int fails;

  // model state per instance
  logic [31:0] m_ctrl [2];
  logic [31:0] m_cnt  [2];
  logic [31:0] m_scr  [2][NREG];

  apb_reg_bank #(.WAIT_CYCLES(WC0)) dut0 (
    .clk(clk), .rst_n(rst_n), .apb_psel(psel[0]), .apb_paddr(paddr),
    .apb_pwrite(pwrite), .apb_penable(penable), .apb_pwdata(pwdata),
    .apb_pready(pready[0]), .apb_prdata(prdata0),
`ifdef APB_PSLVERR_EN
    .apb_pslverr(pslverr[0]),
`endif
    .ctrl_out(ctrl0)
  );

  apb_reg_bank #(.WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .apb_psel(psel[1]), .apb_paddr(paddr),
    .apb_pwrite(pwrite), .apb_penable(penable), .apb_pwdata(pwdata),
    .apb_pready(pready[1]), .apb_prdata(prdata1),
`ifdef APB_PSLVERR_EN
    .apb_pslverr(pslverr[1]),
`endif
    .ctrl_out(ctrl1)
  );

`ifndef APB_PSLVERR_EN
  assign pslverr = 2'b00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? WC0 + 1 : 1;
  endfunction

  function automatic bit is_scr(input int idx);
    return (idx >= 3) && (idx < 3 + NREG);
  endfunction

  function automatic bit wr_err(input int idx);
`ifdef APB_PSLVERR_EN
    return !((idx == 1) || is_scr(idx));
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit rd_err(input int idx);
`ifdef APB_PSLVERR_EN
    return idx >= 3 + NREG;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_ctrl[d] = 32'h0;
      m_cnt[d]  = 32'h0;
      for (int i = 0; i < NREG; i++) m_scr[d][i] = 32'h0;
    end
  endfunction

  function automatic logic [31:0] m_read(input int d, input int idx);
    if (idx == 0) return 32'hA5A5_0100;
    if (idx == 1) return m_ctrl[d];
    if (idx == 2) return m_cnt[d];
    if (is_scr(idx)) return m_scr[d][idx-3];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic void m_write(input int d, input int idx, input logic [31:0] v);
    if (!wr_err(idx)) m_cnt[d] = m_cnt[d] + 32'd1;
    if (idx == 1) m_ctrl[d] = v;
    else if (is_scr(idx)) m_scr[d][idx-3] = v;
  endfunction

  // One complete APB transfer; returns at the falling edge of the pready cycle
  // with the bus still held, so a following transfer can start back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int acc, output logic err);
    bit done;
    done = 1'b0; acc = 0; rd = 32'h0; err = 1'b0;
    @(negedge clk);
    psel = 2'b00; psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      acc++;
      if (pready[d]) begin
        done = 1'b1;
        rd   = (d == 0) ? prdata0 : prdata1;
        err  = pslverr[d];
      end
    end
    if (!done) begin
      check("xfer_timeout", 32'd0, 32'd1);
      psel = 2'b00; penable = 1'b0;
    end
  endtask

  task automatic do_write(input int d, input logic [15:0] a, input logic [31:0] wd);
    logic [31:0] rd; int acc; logic err; int idx;
    idx = int'(a[15:2]);
    xfer(d, 1'b1, a, wd, rd, acc, err);
    check("wr_latency", 32'(acc), 32'(lat(d)));
`ifdef APB_PSLVERR_EN
    check("wr_pslverr", {31'd0, err}, {31'd0, wr_err(idx)});
`endif
    m_write(d, idx, wd);
  endtask

  task automatic do_read(input int d, input logic [15:0] a);
    logic [31:0] rd; int acc; logic err; int idx;
    idx = int'(a[15:2]);
    xfer(d, 1'b0, a, 32'h0, rd, acc, err);
    check("rd_latency", 32'(acc), 32'(lat(d)));
    check("rd_data", rd, m_read(d, idx));
`ifdef APB_PSLVERR_EN
    check("rd_pslverr", {31'd0, err}, {31'd0, rd_err(idx)});
`endif
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 2'b00; penable = 1'b0;
  endtask

  initial begin
    int d; int idx; logic [15:0] a; logic [31:0] v;
    total = 0; passed = 0; fails = 0;
    rst_n = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0; pwdata = 32'h0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_pready", {30'd0, pready}, 32'd0);
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_ctrl0", ctrl0, 32'h0);
    check("rst_ctrl1", ctrl1, 32'h0);
    rst_n = 1'b1;
    idle();

    // ID read with default wait states
    do_read(0, 16'h0000);
    idle();

    // CTRL write, registered ctrl_out, readback, counter
    do_write(0, 16'h0004, 32'h0000_00F1);
    check("ctrl_out_same_cycle", ctrl0, 32'h0);
    idle();
    check("ctrl_out_next_cycle", ctrl0, 32'h0000_00F1);
    do_read(0, 16'h0004);
    do_read(0, 16'h0008);

    // back-to-back scratch writes
    do_write(0, 16'h0028, 32'h1234_5678);
    do_write(0, 16'h000C, 32'hCAFE_0000);
    do_read(0, 16'h0028);
    do_read(0, 16'h000C);
    do_read(0, 16'h0008);

    // unmapped read, write to RO ID
    do_read(0, 16'h0100);
    do_write(0, 16'h0000, 32'hFFFF_FFFF);
    do_read(0, 16'h0000);
    do_read(0, 16'h0008);
    idle();

    // abort in the first access cycle
    @(negedge clk);
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0004; pwdata = 32'h0000_0055;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("abort_pready", {31'd0, pready[0]}, 32'd0);
    psel = 2'b00; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_idle_pready", {31'd0, pready[0]}, 32'd0);
    end
    check("abort_ctrl_out", ctrl0, m_ctrl[0]);
    do_read(0, 16'h0004);
    do_read(0, 16'h0008);

    // reset asserted mid-access
    @(negedge clk);
    psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0018; pwdata = 32'h0000_BEEF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_pready", {31'd0, pready[0]}, 32'd0);
    check("midrst_prdata", prdata0, 32'h0);
    check("midrst_ctrl", ctrl0, 32'h0);
    @(negedge clk);
    psel = 2'b00; penable = 1'b0; rst_n = 1'b1;
    m_reset();
    do_read(0, 16'h0004);
    do_read(0, 16'h0008);
    do_read(0, 16'h0018);
    do_read(0, 16'h0028);
    idle();

    // random traffic to both instances
    for (int n = 0; n < 48; n++) begin
      d = (n % 3 == 2) ? 1 : 0;
      if ($urandom_range(0, 9) == 0) idx = int'($urandom_range(11, 16383));
      else                           idx = int'($urandom_range(0, 11));
      a = 16'(idx * 4 + int'($urandom_range(0, 3)));
      v = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(d, a, v);
      else                           do_read(d, a);
      idle();
      check("rand_ctrl_out", (d == 0) ? ctrl0 : ctrl1, m_ctrl[d]);
    end

    // zero wait states: scratch0 write/read, then counter wrap
    do_write(1, 16'h000C, 32'h0BAD_F00D);
    do_read(1, 16'h000C);
    idle();
    force dut1.wr_cnt_r = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut1.wr_cnt_r;
    m_cnt[1] = 32'hFFFF_FFFF;
    do_read(1, 16'h0008);
    do_write(1, 16'h000C, 32'h0000_0001);
    do_read(1, 16'h0008);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
